// File: rtl/mcu_boot_pkg.sv
// Shared types and constants for the MCU boot sequencer.
// Holds the boot FSM state enum and its width.
package mcu_boot_pkg;

  localparam int unsigned BOOT_STATE_W = 3;

  typedef enum logic [BOOT_STATE_W-1:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_HOLD      = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4,
    ST_HALT      = 3'd5
  } boot_state_t;

endpackage

// File: rtl/mcu_boot_debounce.sv
// Push-button conditioner: 2-flop synchroniser, debounce filter and a
// one-cycle press pulse on each accepted 0->1 level change.
// Ports:
//   clock        system clock
//   reset        synchronous active-high reset
//   raw_input    asynchronous raw button level
//   level_output debounced (accepted) button level
//   press_output one-cycle pulse when the accepted level rises
module mcu_boot_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_input,
  output logic level_output,
  output logic press_output
);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count consecutive cycles where the synchronised input disagrees with the
  // accepted level; any agreeing cycle restarts the count.
  always_comb begin
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = ~level_q;
        press_d = ~level_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_input;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_output = level_q;
  assign press_output = press_q;

endmodule

// File: rtl/mcu_boot_sequencer.sv
// Power-on / run-control sequencer in front of mcu_top_riscv: waits for PLL
// lock, holds the core in reset, releases reset, enables fetch, and supports
// halt / button-resume.
// Optional feature macro: LOCK_TIMEOUT_EN (adds LOCK_TIMEOUT_CYCLES and the
// sticky lock_timeout_output flag).
// Ports:
//   clock, reset              system clock, synchronous active-high reset
//   pll_locked_input          asynchronous PLL lock
//   run_button_input          asynchronous raw resume button
//   halt_request_input        synchronous halt level
//   core_reset_n_output       core reset_n
//   fetch_enable_output       core fetch enable
//   boot_state_output         FSM state encoding
//   boot_done_output          sticky "RUN reached" flag
//   lock_timeout_output       (LOCK_TIMEOUT_EN only) sticky lock timeout
module mcu_boot_sequencer
  import mcu_boot_pkg::*;
#(
  parameter int unsigned RESET_HOLD_CYCLES   = 10,
  parameter int unsigned FETCH_DELAY_CYCLES  = 4,
  parameter int unsigned DEBOUNCE_CYCLES     = 16,
  parameter int unsigned CNT_W               = 16
`ifdef LOCK_TIMEOUT_EN
  ,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 1000
`endif
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    pll_locked_input,
  input  logic                    run_button_input,
  input  logic                    halt_request_input,
  output logic                    core_reset_n_output,
  output logic                    fetch_enable_output,
  output logic [BOOT_STATE_W-1:0] boot_state_output,
  output logic                    boot_done_output
`ifdef LOCK_TIMEOUT_EN
  ,
  output logic                    lock_timeout_output
`endif
);

  boot_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lock_sync1_q, lock_sync2_q;
  logic             core_reset_n_q, core_reset_n_d;
  logic             fetch_en_q, fetch_en_d;
  logic             done_q, done_d;
  logic             lock_loss;
  logic             press;
  logic             btn_level_unused;

  mcu_boot_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_debounce (
    .clock       (clock),
    .reset       (reset),
    .raw_input   (run_button_input),
    .level_output(btn_level_unused),
    .press_output(press)
  );

  // Next state; lock loss outranks halt, halt outranks a button press.
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    lock_loss = 1'b0;
    case (state_q)
      ST_RESET:     state_d = ST_WAIT_LOCK;
      ST_WAIT_LOCK: if (lock_sync2_q) state_d = ST_HOLD;
      ST_HOLD: begin
        if (!lock_sync2_q) begin
          lock_loss = 1'b1;
          state_d   = ST_WAIT_LOCK;
        end else if (cnt_q == CNT_W'(RESET_HOLD_CYCLES - 1)) begin
          state_d = ST_RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        if (!lock_sync2_q) begin
          lock_loss = 1'b1;
          state_d   = ST_WAIT_LOCK;
        end else if (cnt_q == CNT_W'(FETCH_DELAY_CYCLES - 1)) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (!lock_sync2_q) begin
          lock_loss = 1'b1;
          state_d   = ST_WAIT_LOCK;
        end else if (halt_request_input) begin
          state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        if (!lock_sync2_q) begin
          lock_loss = 1'b1;
          state_d   = ST_WAIT_LOCK;
        end else if (!halt_request_input && press) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RESET;
    endcase

    // Outputs decoded from the next state so the registered copies track state_q.
    core_reset_n_d = (state_d == ST_RELEASE) || (state_d == ST_RUN) || (state_d == ST_HALT);
    fetch_en_d     = (state_d == ST_RUN);
    if (lock_loss) begin
      done_d = 1'b0;
    end else if (state_d == ST_RUN) begin
      done_d = 1'b1;
    end else begin
      done_d = done_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_RESET;
      cnt_q          <= '0;
      lock_sync1_q   <= 1'b0;
      lock_sync2_q   <= 1'b0;
      core_reset_n_q <= 1'b0;
      fetch_en_q     <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      lock_sync1_q   <= pll_locked_input;
      lock_sync2_q   <= lock_sync1_q;
      core_reset_n_q <= core_reset_n_d;
      fetch_en_q     <= fetch_en_d;
      done_q         <= done_d;
    end
  end

  assign core_reset_n_output = core_reset_n_q;
  assign fetch_enable_output = fetch_en_q;
  assign boot_state_output   = state_q;
  assign boot_done_output    = done_q;

`ifdef LOCK_TIMEOUT_EN
  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic             timeout_q, timeout_d;

  // Counts cycles spent in WAIT_LOCK; restarts from zero on every entry.
  always_comb begin
    to_cnt_d  = '0;
    timeout_d = timeout_q;
    if (state_q == ST_WAIT_LOCK) begin
      if (to_cnt_q == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
        timeout_d = 1'b1;
        to_cnt_d  = to_cnt_q;
      end else begin
        to_cnt_d = to_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign lock_timeout_output = timeout_q;
`endif

endmodule

// File: tb/tb_mcu_boot_sequencer.sv
// Bench for mcu_boot_sequencer: directed boot/halt scenarios plus a random
// phase. A rule-level model pushes expected output changes into a queue; a
// monitor pops and compares whenever the DUT outputs change.
module tb_mcu_boot_sequencer;

  localparam int H    = 10;
  localparam int F    = 4;
  localparam int D    = 16;
  localparam int MAXC = 20000;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       pll   = 1'b0;
  logic       btn   = 1'b0;
  logic       halt  = 1'b0;
  logic       core_rn, fetch_en, boot_done;
  logic [2:0] boot_state;
`ifdef LOCK_TIMEOUT_EN
  logic       lock_timeout;
`endif

  mcu_boot_sequencer #(
    .RESET_HOLD_CYCLES (H),
    .FETCH_DELAY_CYCLES(F),
    .DEBOUNCE_CYCLES   (D),
    .CNT_W             (16)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .pll_locked_input   (pll),
    .run_button_input   (btn),
    .halt_request_input (halt),
    .core_reset_n_output(core_rn),
    .fetch_enable_output(fetch_en),
    .boot_state_output  (boot_state),
    .boot_done_output   (boot_done)
`ifdef LOCK_TIMEOUT_EN
    ,
    .lock_timeout_output(lock_timeout)
`endif
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int stamp;
    int st;
    bit rn;
    bit fe;
    bit dn;
  } exp_t;
  exp_t expq[$];

  // Reference-model history: synchroniser contents after each edge.
  bit l1[MAXC], l2[MAXC], b1[MAXC], b2[MAXC];
  int m_st = 0;
  bit m_done = 1'b0;
  int m_deadline = 0;
  bit m_lvl = 1'b0;
  bit m_press = 1'b0;
  int m_last_rst = 0;

  function automatic bit rn_of(int s);
    return (s == 3) || (s == 4) || (s == 5);
  endfunction

  // Model: state changes by the boot rules, timed by absolute deadlines.
  initial begin : model
    int  nst;
    bit  lk;
    bit  flip;
    exp_t e;
    forever begin
      @(posedge clock);
      cyc++;
      if (cyc >= MAXC) begin
        $display("FAIL cycle_budget: cycles=%0d limit=%0d", cyc, MAXC);
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "cycle budget exhausted");
      end
      l1[cyc] = reset ? 1'b0 : pll;
      l2[cyc] = reset ? 1'b0 : l1[cyc-1];
      b1[cyc] = reset ? 1'b0 : btn;
      b2[cyc] = reset ? 1'b0 : b1[cyc-1];
      lk  = l2[cyc-1];
      nst = m_st;
      if (reset) begin
        nst    = 0;
        m_done = 1'b0;
      end else begin
        case (m_st)
          0: nst = 1;
          1: if (lk) begin nst = 2; m_deadline = cyc + H; end
          default: begin
            if (!lk) begin
              nst    = 1;
              m_done = 1'b0;
            end else if (m_st == 2 && cyc == m_deadline) begin
              nst        = 3;
              m_deadline = cyc + F;
            end else if (m_st == 3 && cyc == m_deadline) begin
              nst    = 4;
              m_done = 1'b1;
            end else if (m_st == 4 && halt) begin
              nst = 5;
            end else if (m_st == 5 && !halt && m_press) begin
              nst = 4;
            end
          end
        endcase
      end
      // Accepted level flips after D straight samples that disagree with it.
      if (reset) begin
        m_lvl      = 1'b0;
        m_press    = 1'b0;
        m_last_rst = cyc;
      end else begin
        flip = (cyc - D + 1 > m_last_rst);
        if (flip)
          for (int k = 0; k < D; k++)
            if (b2[cyc-k-1] == m_lvl) flip = 1'b0;
        m_press = flip && !m_lvl;
        if (flip) m_lvl = !m_lvl;
      end
      if (nst != m_st) begin
        e.stamp = cyc;
        e.st    = nst;
        e.rn    = rn_of(nst);
        e.fe    = (nst == 4);
        e.dn    = m_done;
        expq.push_back(e);
      end
      m_st = nst;
    end
  end

  // Monitor: every DUT output change must match the next expected change.
  initial begin : monitor
    int p_st;
    bit p_rn, p_fe, p_dn;
    exp_t e;
    p_st = 0; p_rn = 0; p_fe = 0; p_dn = 0;
    forever begin
      @(negedge clock);
      if (mon_en) begin
        while (expq.size() > 0 && expq[0].stamp < cyc) begin
          e = expq.pop_front();
          total++; bad++;
          $display("FAIL missed_change: cycle=%0d no change seen, required state=%0d at cycle %0d",
                   cyc, e.st, e.stamp);
        end
        if (int'(boot_state) != p_st || core_rn != p_rn || fetch_en != p_fe || boot_done != p_dn) begin
          total++;
          if (expq.size() == 0) begin
            bad++;
            $display("FAIL unexpected_change: cycle=%0d state=%0d rn=%0b fe=%0b done=%0b, required no change",
                     cyc, boot_state, core_rn, fetch_en, boot_done);
          end else begin
            e = expq.pop_front();
            if (e.stamp != cyc || e.st != int'(boot_state) || e.rn != core_rn ||
                e.fe != fetch_en || e.dn != boot_done) begin
              bad++;
              $display("FAIL output_change: got cycle=%0d state=%0d rn=%0b fe=%0b done=%0b required cycle=%0d state=%0d rn=%0b fe=%0b done=%0b",
                       cyc, boot_state, core_rn, fetch_en, boot_done, e.stamp, e.st, e.rn, e.fe, e.dn);
            end
          end
        end else if (expq.size() > 0 && expq[0].stamp == cyc) begin
          e = expq.pop_front();
          total++; bad++;
          $display("FAIL no_change: cycle=%0d state=%0d, required state=%0d", cyc, boot_state, e.st);
        end
        p_st = int'(boot_state); p_rn = core_rn; p_fe = fetch_en; p_dn = boot_done;
      end
    end
  end

  task automatic check(input string name, input int got, input int req);
    total++;
    if (got != req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, got, req, cyc);
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clock);
  endtask

  task automatic wait_state(input int s, input int budget, input string name);
    int k = 0;
    while (int'(boot_state) != s && k < budget) begin
      @(negedge clock);
      k++;
    end
    check(name, int'(boot_state), s);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  int e0, r, s, lock_low_left, btn_left;

  initial begin : stim
    // Reset state
    idle(3);
    check("reset_outputs", {boot_state, core_rn, fetch_en, boot_done}, 0);
    mon_en = 1'b1;

    // Boot with lock high from reset release
    reset = 1'b0; pll = 1'b1;
    e0 = cyc + 1;
    wait_cyc(e0 + 11); check("rn_before_e12", core_rn, 0);
    wait_cyc(e0 + 12); check("rn_after_e12", core_rn, 1);
    check("state_release", boot_state, 3);
    wait_cyc(e0 + 15); check("fe_before_e16", fetch_en, 0);
    wait_cyc(e0 + 16); check("fe_after_e16", fetch_en, 1);
    check("done_after_boot", boot_done, 1);

    // Mid-sequence reset, then late lock
    reset = 1'b1; pll = 1'b0;
    idle(1);
    check("midreset_outputs", {boot_state, core_rn, fetch_en, boot_done}, 0);
    idle(2);
    reset = 1'b0;
    idle(50 + $urandom_range(0, 20));
    check("waitlock_state", boot_state, 1);
    check("waitlock_outputs", {core_rn, fetch_en}, 0);
    pll = 1'b1;
    r = cyc + 1;
    wait_cyc(r + 1); check("lock_plus1_state", boot_state, 1);
    wait_cyc(r + 2); check("lock_plus2_state", boot_state, 2);
    wait_state(4, 40, "run_after_late_lock");

    // One-cycle lock drop in RUN
    idle($urandom_range(1, 10));
    pll = 1'b0; idle(1); pll = 1'b1;
    wait_state(1, 6, "lockloss_waitlock");
    check("lockloss_outputs", {core_rn, fetch_en, boot_done}, 0);
    wait_state(4, 40, "resequence_run");

    // Halt, bouncing button, then a clean press resumes
    halt = 1'b1; idle(1); halt = 1'b0;
    wait_state(5, 4, "halt_entered");
    check("halt_fe", fetch_en, 0);
    check("halt_rn", core_rn, 1);
    for (int i = 0; i < 5; i++) begin
      btn = 1'b1; idle(1); btn = 1'b0; idle(1);
    end
    btn = 1'b1;
    s = cyc + 1;
    wait_cyc(s + D + 1); check("press_not_yet", boot_state, 5);
    wait_cyc(s + D + 2); check("press_resume", boot_state, 4);
    wait_cyc(s + 20);
    btn = 1'b0;
    idle(D + 6);
    check("single_press_run", boot_state, 4);

    // Press with halt held is discarded and not queued
    halt = 1'b1;
    wait_state(5, 4, "halt_held");
    btn = 1'b1; idle(25); btn = 1'b0; idle(25);
    check("press_halt_high", boot_state, 5);
    halt = 1'b0;
    idle(30);
    check("no_queued_press", boot_state, 5);
    btn = 1'b1;
    wait_state(4, 40, "resume_after_release");
    btn = 1'b0; idle(25);

    // Random phase
    lock_low_left = 0; btn_left = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if (lock_low_left > 0) begin
        lock_low_left--;
        pll = (lock_low_left == 0);
      end else if ($urandom_range(0, 299) == 0) begin
        pll = 1'b0;
        lock_low_left = $urandom_range(1, 8);
      end
      if ($urandom_range(0, 99) < 3) halt = 1'b1;
      else if ($urandom_range(0, 9) == 0) halt = 1'b0;
      if (btn_left > 0) btn_left--;
      else begin
        btn = ~btn;
        btn_left = $urandom_range(0, 40);
      end
      reset = ($urandom_range(0, 999) == 0);
    end
    reset = 1'b0; pll = 1'b1; halt = 1'b0; btn = 1'b0;
    idle(60);
    check("scoreboard_drained", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: time=%0t limit=500000", $time);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mcu_boot_sequencer.md
Name: mcu_boot_sequencer

Overview:
Power-on and run-control sequencer that sits directly upstream of mcu_top_riscv. It drives the core's reset_n and fetch_enable_input.
- Waits for PLL lock.
- Holds the core in reset for a programmable time.
- Releases reset, then enables instruction fetch after a further delay.
- Supports halt and resume via a debounced board push-button.

Parameters:
RESET_HOLD_CYCLES, 10, cycles core_reset_n_output is held low after lock (>=1)
FETCH_DELAY_CYCLES, 4, cycles between reset release and fetch enable (>=1)
DEBOUNCE_CYCLES, 16, consecutive stable cycles required to accept a button level change (>=1)
CNT_W, 16, width of internal delay/debounce counters; all cycle parameters must be < 2**CNT_W

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
pll_locked_input  input  1  PLL lock, asynchronous to clock
run_button_input  input  1  raw push-button, asynchronous, active-high
halt_request_input  input  1  synchronous level request to stop fetch
core_reset_n_output  output  1  active-low reset to mcu_top_riscv reset_n
fetch_enable_output  output  1  to mcu_top_riscv fetch_enable_input
boot_state_output  output  3  current FSM state encoding
boot_done_output  output  1  sticky: RUN reached since last reset or lock loss

Behaviour:
- One clock domain, clock. Reset is synchronous, active-high.
- During reset: state=RESET, all sync/debounce flops=0, counters=0.
- Output values during reset: core_reset_n_output=0, fetch_enable_output=0, boot_state_output=0, boot_done_output=0.
- Outputs are a Moore decode of registered state. There is no combinational path from any input to any output.
- Synchronisers: pll_locked_input and run_button_input each pass through a 2-flop synchroniser. halt_request_input is used directly.
- State encoding: RESET=0, WAIT_LOCK=1, HOLD=2, RELEASE=3, RUN=4, HALT=5. Values 6 and 7 are unreachable and recover to RESET.
- Timing reference E0 is the first edge with reset=0.
  - RESET -> WAIT_LOCK at E0, unconditionally.
  - WAIT_LOCK -> HOLD when the synchronised lock is 1. The earliest transition is E2.
  - HOLD: counter cleared on entry; exit when counter==RESET_HOLD_CYCLES-1 -> RELEASE. HOLD lasts exactly RESET_HOLD_CYCLES cycles.
  - RELEASE: counter cleared on entry; lasts exactly FETCH_DELAY_CYCLES cycles -> RUN.
  - RUN -> HALT when halt_request_input=1.
  - HALT -> RUN on a button press event while halt_request_input=0.
- Lock loss: synchronised lock=0 in HOLD, RELEASE, RUN or HALT -> WAIT_LOCK on the next edge. Lock loss also clears boot_done_output.
- Priority when events coincide: reset > lock loss > halt_request > button press. A press in HALT with halt still high is discarded.
- Output decode:
  - core_reset_n_output=1 in RELEASE, RUN and HALT; 0 otherwise.
  - fetch_enable_output=1 only in RUN.
  - boot_done_output is set on entry to RUN.
- With defaults and lock stable high:
  - core_reset_n_output rises after E12.
  - fetch_enable_output rises after E16.
- Debounce:
  - The accepted level changes when the synchronised button has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the count.
  - A press event is a one-cycle pulse on the accepted level's 0->1 transition. Press events outside HALT are ignored and are not queued.
- A reset asserted mid-sequence returns to RESET at that edge, with no partial outputs.

Optional Feature:
LOCK_TIMEOUT_EN.
- When defined:
  - Adds parameter LOCK_TIMEOUT_CYCLES (default 1000).
  - Adds output lock_timeout_output (1 bit, reset 0).
  - If the FSM stays in WAIT_LOCK for LOCK_TIMEOUT_CYCLES consecutive cycles, lock_timeout_output is set and remains sticky until reset. The FSM keeps waiting.
  - The timeout counter clears on each entry to WAIT_LOCK.
- When undefined: no timeout counter and no extra port.

Decomposition:
- Package mcu_boot_pkg holds:
  - boot_state_t enum (3-bit, encodings above).
  - Localparam BOOT_STATE_W=3.
- One sub-module, mcu_boot_debounce, containing the 2-flop synchroniser, the debounce counter and the press pulse generator.
  - Parameters: DEBOUNCE_CYCLES, CNT_W.
  - Ports: clock, reset, raw_input, level_output, press_output.

Test Plan:
- Default parameters, lock high from reset release -> state sequence 1,2,3,4; core_reset_n_output=1 after E12; fetch_enable_output=1 after E16; boot_done_output=1.
- Lock held low for 50 cycles, then raised -> state stays WAIT_LOCK with both outputs 0; HOLD is entered 2 cycles after the rise; timing afterwards as in the first scenario.
- In RUN, drop lock for 1 cycle -> next edges: WAIT_LOCK, core_reset_n_output=0, fetch_enable_output=0, boot_done_output=0; full resequence follows.
- In RUN, pulse halt_request_input:
  - HALT entered, fetch_enable_output=0, core_reset_n_output stays 1.
  - Button bouncing 5 on/off cycles, then held 20 cycles -> exactly one press; RUN resumes DEBOUNCE_CYCLES+2 cycles after the stable high begins.
- In HALT, press the button with halt_request_input still 1 -> stays HALT. Release halt without pressing -> stays HALT (no queued press).
- With LOCK_TIMEOUT_EN and LOCK_TIMEOUT_CYCLES=100, lock held low -> lock_timeout_output=1 after 100 cycles in WAIT_LOCK. A later lock completes the boot with the flag still 1. Reset clears it.
